// File: rtl/not_gate.sv
// Bitwise inverter with a registered shadow copy and optional transition monitor.
// Monitor (a_rise/a_fall/trans_cnt/cnt_clr) is built only when NOTGATE_MONITOR_EN is defined.
module not_gate #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] b_q,
  output logic [WIDTH-1:0] a_rise,
  output logic [WIDTH-1:0] a_fall,
  output logic [CNT_W-1:0] trans_cnt,
  input  logic             cnt_clr
);

  logic [WIDTH-1:0] b_reg_q;

  // Pure combinational path; independent of clock and reset.
  assign b   = ~a;
  assign b_q = b_reg_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_reg_q <= '1;
    end else begin
      b_reg_q <= ~a;
    end
  end

`ifdef NOTGATE_MONITOR_EN

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [WIDTH-1:0] a_last_q;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             changed;

  always_comb begin
    rise_d  = a & ~a_last_q;
    fall_d  = ~a & a_last_q;
    changed = |(a ^ a_last_q);
    cnt_d   = cnt_q;
    // Clear wins over a same-cycle increment.
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (changed) begin
      cnt_d = sat_inc(cnt_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_last_q <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      cnt_q    <= '0;
    end else begin
      a_last_q <= a;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      cnt_q    <= cnt_d;
    end
  end

  assign a_rise    = rise_q;
  assign a_fall    = fall_q;
  assign trans_cnt = cnt_q;

`else

  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;

  assign a_rise    = '0;
  assign a_fall    = '0;
  assign trans_cnt = '0;

`endif

endmodule

// File: tb/tb_not_gate.sv
// Directed bench for not_gate: main instance WIDTH=4/CNT_W=16, saturation instance WIDTH=1/CNT_W=3.
module tb_not_gate;

`ifdef NOTGATE_MONITOR_EN
  localparam bit MON = 1'b1;
`else
  localparam bit MON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  a = 4'b0000;
  logic [3:0]  b, b_q, a_rise, a_fall;
  logic [15:0] trans_cnt;
  logic        cnt_clr = 1'b0;

  logic        a_s = 1'b0;
  logic        b_s, b_q_s, rise_s, fall_s;
  logic [2:0]  cnt_s;
  logic        cnt_clr_s = 1'b0;

  int tests = 0;
  int fails = 0;

  not_gate #(.WIDTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .b_q(b_q),
    .a_rise(a_rise), .a_fall(a_fall), .trans_cnt(trans_cnt), .cnt_clr(cnt_clr)
  );

  not_gate #(.WIDTH(1), .CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .a(a_s), .b(b_s), .b_q(b_q_s),
    .a_rise(rise_s), .a_fall(fall_s), .trans_cnt(cnt_s), .cnt_clr(cnt_clr_s)
  );

  always #5 if (clk_en) clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_edge();
    @(negedge clk);
  endtask

  task automatic test_comb_noclk();
    a = 4'b0000; #1;
    tests++; if (b !== 4'b1111) begin fails++; $display("FAIL comb_a0 b=%b exp=%b", b, 4'b1111); end
    a = 4'b1111; #1;
    tests++; if (b !== 4'b0000) begin fails++; $display("FAIL comb_a1 b=%b exp=%b", b, 4'b0000); end
    a = 4'b0110; a_s = 1'b1; #1;
    tests++; if (b !== 4'b1001) begin fails++; $display("FAIL comb_a6 b=%b exp=%b", b, 4'b1001); end
    tests++; if (b_s !== 1'b0) begin fails++; $display("FAIL comb_sat b=%b exp=0", b_s); end
    a = 4'b0000; a_s = 1'b0; #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a = 4'b1111; #1;
    tests++; if (b !== 4'b0000) begin fails++; $display("FAIL rst_b b=%b exp=%b", b, 4'b0000); end
    tests++; if (b_q !== 4'b1111) begin fails++; $display("FAIL rst_bq b_q=%b exp=%b", b_q, 4'b1111); end
    clk_en = 1'b1;
    repeat (3) tick();
    tests++; if (b_q !== 4'b1111) begin fails++; $display("FAIL rst_bq_clk b_q=%b exp=%b", b_q, 4'b1111); end
    tests++; if (trans_cnt !== 16'd0 || a_rise !== 4'b0 || a_fall !== 4'b0) begin
      fails++; $display("FAIL rst_mon cnt=%0d rise=%b fall=%b exp 0", trans_cnt, a_rise, a_fall);
    end
    tests++; if (b_q_s !== 1'b1 || cnt_s !== 3'd0) begin
      fails++; $display("FAIL rst_sat b_q=%b cnt=%0d exp 1/0", b_q_s, cnt_s);
    end
    drive_edge();
    a = 4'b0000;
    rst = 1'b0;
    tick();
    tests++; if (b_q !== 4'b1111 || trans_cnt !== 16'd0) begin
      fails++; $display("FAIL rst_release b_q=%b cnt=%0d exp 1111/0", b_q, trans_cnt);
    end
  endtask

  task automatic test_rise_fall();
    drive_edge();
    a = 4'b0101; #1;
    tests++; if (b !== 4'b1010) begin fails++; $display("FAIL rf_comb b=%b exp=%b", b, 4'b1010); end
    tick();
    tests++; if (b_q !== 4'b1010) begin fails++; $display("FAIL rf_bq b_q=%b exp=%b", b_q, 4'b1010); end
    tests++; if (a_rise !== (MON ? 4'b0101 : 4'b0000) || a_fall !== 4'b0000) begin
      fails++; $display("FAIL rf_rise rise=%b fall=%b exp=%b/0000", a_rise, a_fall, MON ? 4'b0101 : 4'b0000);
    end
    tests++; if (trans_cnt !== (MON ? 16'd1 : 16'd0)) begin
      fails++; $display("FAIL rf_cnt1 cnt=%0d exp=%0d", trans_cnt, MON ? 1 : 0);
    end
    tick();
    tests++; if (a_rise !== 4'b0000 || b_q !== 4'b1010) begin
      fails++; $display("FAIL rf_pulse_len rise=%b b_q=%b exp 0000/1010", a_rise, b_q);
    end
    drive_edge();
    a = 4'b0000;
    tick();
    tests++; if (a_fall !== (MON ? 4'b0101 : 4'b0000) || a_rise !== 4'b0000) begin
      fails++; $display("FAIL rf_fall fall=%b rise=%b exp=%b/0000", a_fall, a_rise, MON ? 4'b0101 : 4'b0000);
    end
    tests++; if (trans_cnt !== (MON ? 16'd2 : 16'd0) || b_q !== 4'b1111) begin
      fails++; $display("FAIL rf_cnt2 cnt=%0d b_q=%b exp=%0d/1111", trans_cnt, b_q, MON ? 2 : 0);
    end
    tick();
    tests++; if (a_fall !== 4'b0000) begin fails++; $display("FAIL rf_fall_len fall=%b exp=0000", a_fall); end
  endtask

  task automatic test_count_clear();
    drive_edge();
    cnt_clr = 1'b1;
    tick();
    tests++; if (trans_cnt !== 16'd0) begin fails++; $display("FAIL cc_clr0 cnt=%0d exp=0", trans_cnt); end
    drive_edge();
    cnt_clr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      a = ~a;
      tick();
      tests++; if (b_q !== ~a) begin fails++; $display("FAIL cc_bq%0d b_q=%b exp=%b", i, b_q, ~a); end
      drive_edge();
    end
    tests++; if (trans_cnt !== (MON ? 16'd10 : 16'd0)) begin
      fails++; $display("FAIL cc_ten cnt=%0d exp=%0d", trans_cnt, MON ? 10 : 0);
    end
    a = ~a;
    cnt_clr = 1'b1;
    tick();
    tests++; if (trans_cnt !== 16'd0) begin fails++; $display("FAIL cc_clr_prio cnt=%0d exp=0", trans_cnt); end
    drive_edge();
    cnt_clr = 1'b0;
    a = ~a;
    tick();
    tests++; if (trans_cnt !== (MON ? 16'd1 : 16'd0)) begin
      fails++; $display("FAIL cc_after cnt=%0d exp=%0d", trans_cnt, MON ? 1 : 0);
    end
  endtask

  task automatic test_saturate();
    drive_edge();
    cnt_clr_s = 1'b1;
    tick();
    drive_edge();
    cnt_clr_s = 1'b0;
    for (int i = 0; i < 9; i++) begin
      a_s = ~a_s;
      tick();
      if (i == 6) begin
        tests++; if (cnt_s !== (MON ? 3'd7 : 3'd0)) begin
          fails++; $display("FAIL sat_seven cnt=%0d exp=%0d", cnt_s, MON ? 7 : 0);
        end
      end
      drive_edge();
    end
    tests++; if (cnt_s !== (MON ? 3'd7 : 3'd0)) begin
      fails++; $display("FAIL sat_hold cnt=%0d exp=%0d", cnt_s, MON ? 7 : 0);
    end
    tests++; if (b_q_s !== ~a_s) begin fails++; $display("FAIL sat_bq b_q=%b exp=%b", b_q_s, ~a_s); end
  endtask

  task automatic test_async_reset();
    drive_edge();
    a = 4'b1010;
    tick();
    #2;
    rst = 1'b1;
    #1;
    tests++; if (b_q !== 4'b1111 || trans_cnt !== 16'd0 || a_rise !== 4'b0000) begin
      fails++; $display("FAIL ar_clear b_q=%b cnt=%0d rise=%b exp 1111/0/0000", b_q, trans_cnt, a_rise);
    end
    tests++; if (b !== 4'b0101) begin fails++; $display("FAIL ar_b b=%b exp=%b", b, 4'b0101); end
    drive_edge();
    rst = 1'b0;
    tick();
    tests++; if (a_rise !== (MON ? 4'b1010 : 4'b0000) || trans_cnt !== (MON ? 16'd1 : 16'd0)) begin
      fails++; $display("FAIL ar_first rise=%b cnt=%0d exp=%b/%0d", a_rise, trans_cnt, MON ? 4'b1010 : 4'b0000, MON ? 1 : 0);
    end
    tests++; if (b_q !== 4'b0101) begin fails++; $display("FAIL ar_bq b_q=%b exp=%b", b_q, 4'b0101); end
  endtask

  initial begin
    test_comb_noclk();
    test_reset();
    test_rise_fall();
    test_count_clear();
    test_saturate();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
